fp_align_stage: RTL

- Mantissa-alignment stage of the FPU adder datapath. Sits directly downstream of the exponent-difference stage and consumes its bigger exponent and shift magnitude.
- Right-shifts the smaller operand's mantissa by the exponent difference, one bit per cycle, accumulating guard, round and sticky (G/R/S) bits.
- Presents both aligned mantissas to the add/normalise stage through a valid/ready handshake.

---
 rtl/fp_align_stage.sv | 98 +++++++++
 1 files changed

// File: rtl/fp_align_stage.sv
// FPU adder mantissa-alignment stage: shifts the smaller mantissa right by the
// exponent difference one bit per cycle, folding shifted-out bits into G/R/S.
module fp_align_stage #(
  parameter  int unsigned EXP_W  = 4,
  parameter  int unsigned MANT_W = 4,
  localparam int unsigned EXT_W  = MANT_W + 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [EXP_W-1:0]  i_exp_big,
  input  logic [EXP_W-1:0]  i_shift_amt,
  input  logic [MANT_W-1:0] i_mant_big,
  input  logic [MANT_W-1:0] i_mant_small,
  input  logic              i_sign_big,
  input  logic              i_sign_small,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [EXP_W-1:0]  o_exp,
  output logic [EXT_W-1:0]  o_mant_big,
  output logic [EXT_W-1:0]  o_mant_small,
  output logic              o_sign_big,
  output logic              o_sign_small
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [EXP_W-1:0] cnt;
  logic             sat;

  assign sat = 32'(i_shift_amt) >= EXT_W;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      o_valid      <= 1'b0;
      o_ready      <= 1'b1;
      o_exp        <= '0;
      o_mant_big   <= '0;
      o_mant_small <= '0;
      o_sign_big   <= 1'b0;
      o_sign_small <= 1'b0;
    end else if (i_flush) begin
      state   <= IDLE;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            o_exp        <= i_exp_big;
            o_sign_big   <= i_sign_big;
            o_sign_small <= i_sign_small;
            o_mant_big   <= {i_mant_big, 3'b000};
            // A shift past the whole extended width leaves only the sticky bit.
            if (sat) begin
              o_mant_small <= {{(EXT_W-1){1'b0}}, |i_mant_small};
              cnt          <= '0;
            end else begin
              o_mant_small <= {i_mant_small, 3'b000};
              cnt          <= i_shift_amt;
            end
            state   <= SHIFT;
            o_ready <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            state   <= DONE;
            o_valid <= 1'b1;
          end else begin
            o_mant_small <= {1'b0, o_mant_small[EXT_W-1:2],
                             o_mant_small[1] | o_mant_small[0]};
            cnt          <= cnt - {{(EXP_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
